// File: rtl/subleq_ctrl.sv
// Run controller for the subleq core: loads a host program into the shared RAM, runs the core,
// and ends the run on halt write, step limit or abort. Halt detection is enabled by SUBLEQ_CTRL_HALT_EN.
module subleq_ctrl #(
  parameter int                BITS      = 8,
  parameter logic [BITS-1:0]   HALT_ADDR = {BITS{1'b1}},
  parameter int                STEP_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [BITS-1:0]   load_count,
  input  logic [STEP_W-1:0] step_limit,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [BITS-1:0]   load_data,
  output logic              core_reset,
  input  logic              core_write,
  input  logic [BITS-1:0]   core_address,
  input  logic [BITS-1:0]   core_wdata,
  output logic [BITS-1:0]   core_rdata,
  output logic              mem_we,
  output logic [BITS-1:0]   mem_address,
  output logic [BITS-1:0]   mem_wdata,
  input  logic [BITS-1:0]   mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [STEP_W-1:0] steps
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [BITS-1:0]   ADDR_ONE = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [BITS-1:0]     load_cnt_q, load_cnt_d;
  logic [BITS-1:0]     load_addr_q, load_addr_d;
  logic [STEP_W-1:0]   limit_q, limit_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [1:0]          cause_q, cause_d;
  logic                load_ready_q, load_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                halt_hit;
  logic [STEP_W-1:0]   steps_inc;

`ifdef SUBLEQ_CTRL_HALT_EN
  assign halt_hit = core_write && (core_address == HALT_ADDR);
`else
  assign halt_hit = 1'b0;
`endif

  // Step counter saturates rather than wrapping so a long unlimited run never reports a small count.
  assign steps_inc = (&steps_q) ? steps_q : (steps_q + STEP_ONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      load_cnt_q   <= '0;
      load_addr_q  <= '0;
      limit_q      <= '0;
      steps_q      <= '0;
      cause_q      <= 2'd0;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      load_addr_q  <= load_addr_d;
      limit_q      <= limit_d;
      steps_q      <= steps_d;
      cause_q      <= cause_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    load_addr_d = load_addr_q;
    limit_d     = limit_q;
    steps_d     = steps_q;
    cause_d     = cause_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          steps_d     = '0;
          cause_d     = 2'd0;
          load_cnt_d  = load_count;
          limit_d     = step_limit;
          load_addr_d = '0;
          state_d     = (load_count != '0) ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: begin
        if (abort) begin
          cause_d = 2'd3;
          state_d = S_DONE;
        end else if (load_valid && load_ready_q) begin
          load_addr_d = load_addr_q + ADDR_ONE;
          if (load_addr_q == (load_cnt_q - ADDR_ONE)) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Abort outranks halt, which outranks the step limit.
        if (abort) begin
          cause_d = 2'd3;
          state_d = S_DONE;
        end else if (core_write) begin
          steps_d = steps_inc;
          if (halt_hit) begin
            cause_d = 2'd1;
            state_d = S_DONE;
          end else if ((limit_q != '0) && (steps_inc == limit_q)) begin
            cause_d = 2'd2;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    load_ready_d = (state_d == S_LOAD);
    busy_d       = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
  end

  // RAM port mux: host owns it in LOAD, the core in RUN, idle (all zero) otherwise.
  always_comb begin
    mem_we      = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    core_rdata  = '0;
    case (state_q)
      S_LOAD: begin
        mem_we      = load_valid && load_ready_q && !abort;
        mem_address = load_addr_q;
        mem_wdata   = load_data;
      end
      S_RUN: begin
        mem_we      = core_write && !abort && !halt_hit;
        mem_address = core_address;
        mem_wdata   = core_wdata;
        core_rdata  = mem_rdata;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign core_reset = (state_q != S_RUN);
  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign halt_cause = cause_q;
  assign steps      = steps_q;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Randomized bench for subleq_ctrl: acts as host and core, models the RAM contents and run outcome.
module tb_subleq_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [7:0]  load_count;
  logic [15:0] step_limit;
  logic        load_valid, load_ready;
  logic [7:0]  load_data;
  logic        core_reset, core_write;
  logic [7:0]  core_address, core_wdata, core_rdata;
  logic        mem_we;
  logic [7:0]  mem_address, mem_wdata, mem_rdata;
  logic        busy, done;
  logic [1:0]  halt_cause;
  logic [15:0] steps;

  logic [7:0]  ram [256];
  logic [7:0]  exp_ram [256];
  logic [7:0]  ld [256];
  logic        clr;
  int          n_tests = 0;
  int          n_fail  = 0;

`ifdef SUBLEQ_CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  subleq_ctrl dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .load_count(load_count), .step_limit(step_limit),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .core_reset(core_reset), .core_write(core_write), .core_address(core_address),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .halt_cause(halt_cause), .steps(steps)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_address] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rst();
    check("rst_load_ready", {31'd0, load_ready}, 32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_mem_we",     {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr",   {24'd0, mem_address}, 32'd0);
    check("rst_mem_wdata",  {24'd0, mem_wdata}, 32'd0);
    check("rst_busy_done",  {30'd0, busy, done}, 32'd0);
    check("rst_cause",      {30'd0, halt_cause}, 32'd0);
    check("rst_steps",      {16'd0, steps}, 32'd0);
  endtask

  // One complete start..done..idle sequence; halt_at/abort_at are indices of core writes, load_abort of transfers.
  task automatic do_run(input int n_load, input int limit, input bit toggle,
                        input int halt_at, input int abort_at, input int load_abort);
    int xfer, guard, cyc, wr, we_cnt, mism, exp_steps, exp_cause;
    bit ended, w, ab;
    logic [7:0] a, d;
    start = 1'b1; load_count = n_load[7:0]; step_limit = limit[15:0];
    @(posedge clock); #1;
    start = 1'b0;
    exp_steps = 0; exp_cause = 0; ended = 1'b0; we_cnt = 0; xfer = 0; guard = 0;
    if (n_load != 0) check("start_to_ready", {31'd0, load_ready}, 32'd1);
    else             check("cnt0_run", {31'd0, core_reset}, 32'd0);
    while (xfer < n_load && !ended && guard < 4 * n_load + 4) begin
      load_valid = toggle ? (guard % 2 == 0) : 1'b1;
      load_data  = ld[xfer];
      ab = load_valid && (xfer == load_abort);
      abort = ab;
      #1;
      we_cnt += int'(mem_we);
      if (load_valid && !ab) check("ld_addr", {24'd0, mem_address}, xfer);
      @(posedge clock); #1;
      abort = 1'b0; load_valid = 1'b0;
      if (ab) begin
        ended = 1'b1; exp_cause = 3;
      end else if (guard % 2 == 0 || !toggle) begin
        exp_ram[xfer] = ld[xfer];
        xfer++;
      end
      guard++;
    end
    check("we_pulses", we_cnt, xfer);
    if (!ended) begin
      check("ld_complete", xfer, n_load);
      if (xfer != n_load) ended = 1'b1;
      else if (n_load != 0) check("run_after_load", {31'd0, core_reset}, 32'd0);
    end
    cyc = 0; wr = 0;
    while (!ended && cyc <= 200) begin
      w = ($urandom_range(0, 9) < 7);
      a = 8'($urandom); if (a == 8'hFF) a = 8'hFE;
      if (w && wr == halt_at) a = 8'hFF;
      d = 8'($urandom);
      ab = (w && wr == abort_at) || (cyc == 200);
      core_write = w; core_address = a; core_wdata = d; abort = ab;
      start = ($urandom_range(0, 7) == 0);
      #1;
      check("rdata", {24'd0, core_rdata}, {24'd0, exp_ram[a]});
      check("we_mux", {31'd0, mem_we}, {31'd0, w && !ab && !(HALT_EN && a == 8'hFF)});
      @(posedge clock); #1;
      core_write = 1'b0; abort = 1'b0; start = 1'b0;
      if (ab) begin
        ended = 1'b1; exp_cause = 3;
      end else if (w) begin
        if (exp_steps < 65535) exp_steps++;
        if (HALT_EN && a == 8'hFF) begin
          ended = 1'b1; exp_cause = 1;
        end else begin
          exp_ram[a] = d;
          if (limit != 0 && exp_steps == limit) begin
            ended = 1'b1; exp_cause = 2;
          end
        end
      end
      if (w) wr++;
      if (!ended) check("running", {30'd0, done, core_reset}, 32'd0);
      cyc++;
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("cause", {30'd0, halt_cause}, exp_cause);
    if (exp_cause != 3) check("steps", {16'd0, steps}, exp_steps);
    @(posedge clock); #1;
    check("done_once", {31'd0, done}, 32'd0);
    check("idle_core_rst", {31'd0, core_reset}, 32'd1);
    check("cause_held", {30'd0, halt_cause}, exp_cause);
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) mism++;
    check("ram", mism, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; load_count = 8'd0; step_limit = 16'd0;
    load_valid = 1'b0; load_data = 8'd0; core_write = 1'b0; core_address = 8'd0; core_wdata = 8'd0;
    clr = 1'b1;
    for (int i = 0; i < 256; i++) begin exp_ram[i] = 8'h00; ld[i] = 8'($urandom); end
    repeat (2) @(posedge clock); #1;
    check_rst();
    clr = 1'b0; reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 4; i++) ld[i] = 8'(i + 3);
    do_run(4, 3, 1'b1, -1, -1, -1);
    for (int i = 0; i < 256; i++) ld[i] = 8'($urandom);
    do_run(10, 2, 1'b0, 1, -1, -1);
    do_run(5, 2, 1'b0, 1, 1, -1);
    do_run(0, 0, 1'b0, 3, -1, -1);
    do_run(6, 0, 1'b0, -1, -1, 3);
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 256; i++) ld[i] = 8'($urandom);
      do_run($urandom_range(0, 20), $urandom_range(0, 30), 1'($urandom),
             $urandom_range(0, 1) ? $urandom_range(0, 20) : -1,
             $urandom_range(0, 1) ? $urandom_range(0, 25) : -1,
             ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1);
    end

    start = 1'b1; load_count = 8'd0; step_limit = 16'd0;
    @(posedge clock); #1;
    start = 1'b0;
    core_write = 1'b1; core_address = 8'h01; core_wdata = 8'h55;
    repeat (3) @(posedge clock);
    #1;
    check("pre_rst_steps", {16'd0, steps}, 32'd3);
    reset_n = 1'b0;
    #1;
    check_rst();
    core_write = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
